// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner with press/release
// debounce and a valid/ack key handshake with sticky overrun.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEBOUNCE_CNT = 500000,
    parameter int unsigned REPEAT_DELAY = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    input  logic       key_ack,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       overrun
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DB_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);

    // Reject parameter values the counters cannot represent
    if (SCAN_DIV < 4) begin : g_bad_scan_div
        $error("keypad_scan: SCAN_DIV must be 4 or more");
    end
    if (DEBOUNCE_CNT < 1) begin : g_bad_debounce
        $error("keypad_scan: DEBOUNCE_CNT must be 1 or more");
    end
    if (REPEAT_DELAY < 1) begin : g_bad_repeat
        $error("keypad_scan: REPEAT_DELAY must be 1 or more");
    end

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       col_meta, col_s;
    logic [1:0]       row_idx, row_idx_nxt;
    logic [1:0]       col_idx, col_idx_nxt;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic [DB_W-1:0]  db_cnt, db_cnt_nxt;
    logic [3:0]       row_out_nxt, key_code_nxt;
    logic             key_valid_nxt, overrun_nxt;
    logic             commit_c, hit_c, key_up_c;
    logic [1:0]       hit_col_c;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_DELAY - 1);
    logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
`endif

    // Two-flop synchronizer for the asynchronous column lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= 4'b1111;
            col_s    <= 4'b1111;
        end else begin
            col_meta <= col_in;
            col_s    <= col_meta;
        end
    end

    // Lowest-index pressed column on the driven row, and state of the watched column
    always_comb begin
        hit_col_c = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!col_s[i]) hit_col_c = 2'(i);
        end
        hit_c    = ~&col_s;
        key_up_c = col_s[col_idx];
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            row_idx   <= 2'd0;
            col_idx   <= 2'd0;
            div_cnt   <= '0;
            db_cnt    <= '0;
            row_out   <= 4'b1110;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            row_idx   <= row_idx_nxt;
            col_idx   <= col_idx_nxt;
            div_cnt   <= div_cnt_nxt;
            db_cnt    <= db_cnt_nxt;
            row_out   <= row_out_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            overrun   <= overrun_nxt;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_cnt <= '0;
        else     rep_cnt <= rep_cnt_nxt;
    end
`endif

    // Next-state, counters and handshake outputs
    always_comb begin
        state_nxt     = state;
        row_idx_nxt   = row_idx;
        col_idx_nxt   = col_idx;
        div_cnt_nxt   = div_cnt;
        db_cnt_nxt    = db_cnt;
        commit_c      = 1'b0;
        key_code_nxt  = key_code;
        key_valid_nxt = key_valid;
        overrun_nxt   = overrun;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_cnt_nxt   = '0;
`endif

        case (state)
            SCAN: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt = '0;
                    if (hit_c) begin
                        col_idx_nxt = hit_col_c;
                        db_cnt_nxt  = '0;
                        state_nxt   = PRESS_DB;
                    end else begin
                        row_idx_nxt = row_idx + 2'd1;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end

            PRESS_DB: begin
                if (key_up_c) begin
                    // Bounce: abandon this key and move on to the next row
                    db_cnt_nxt  = '0;
                    div_cnt_nxt = '0;
                    row_idx_nxt = row_idx + 2'd1;
                    state_nxt   = SCAN;
                end else if (db_cnt == DB_LAST) begin
                    db_cnt_nxt = '0;
                    commit_c   = 1'b1;
                    state_nxt  = HELD;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end

            HELD: begin
                if (!key_up_c) begin
                    db_cnt_nxt = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (rep_cnt == REP_LAST) begin
                        commit_c    = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + REP_W'(1);
                    end
`endif
                end else if (db_cnt == DB_LAST) begin
                    db_cnt_nxt  = '0;
                    div_cnt_nxt = '0;
                    row_idx_nxt = row_idx + 2'd1;
                    state_nxt   = SCAN;
                end else begin
                    db_cnt_nxt = db_cnt + DB_W'(1);
                end
            end

            default: begin
                state_nxt = SCAN;
            end
        endcase

        // A commit with ack in the same cycle replaces the code and clears overrun
        if (commit_c) begin
            if (!key_valid || key_ack) begin
                key_code_nxt  = {row_idx, col_idx};
                key_valid_nxt = 1'b1;
                overrun_nxt   = 1'b0;
            end else begin
                overrun_nxt = 1'b1;
            end
        end else if (key_valid && key_ack) begin
            key_valid_nxt = 1'b0;
            overrun_nxt   = 1'b0;
        end

        row_out_nxt = ~(4'b0001 << row_idx_nxt);
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 active-low matrix keypad, debounces the first detected key, and presents a 4-bit key code with a valid/ack handshake.
- Input-side counterpart of the multiplexed seven-segment output scanner; feeds the front-panel control FSM.
- Single clock domain; column inputs are asynchronous and synchronized internally.

Parameters:
- SCAN_DIV, 50000: clock cycles each row stays driven; legal values are 4 and above.
- DEBOUNCE_CNT, 500000: consecutive stable cycles needed to confirm a press or a release; legal values are 1 and above.
- REPEAT_DELAY, 25000000: cycles a key is held between auto-repeat events; used only with the optional feature.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- col_in  input  4  keypad columns, active-low, pulled up externally, asynchronous
- key_ack  input  1  consumer accepts key_code; sampled on the clock edge
- row_out  output  4  row drive, one-cold; a 0 drives that row
- key_code  output  4  {row[1:0], col[1:0]}, i.e. row*4+col
- key_valid  output  1  key_code holds an unconsumed key
- overrun  output  1  sticky flag: a key was dropped while key_valid was high

Behaviour:
- Reset values (asynchronous on rst high):
  - row_out=4'b1110, key_code=0, key_valid=0, overrun=0.
  - state=SCAN, row index=0, all counters=0, synchronizer flops=4'b1111.
- Synchronization: col_in passes through a 2-flop synchronizer. All column decisions use the synchronized value (col_s).
- SCAN state:
  - Row index r advances every SCAN_DIV cycles and wraps 3->0. row_out = ~(1<<r).
  - col_s is evaluated only on the last cycle of each row period.
  - If any col_s bit is 0, the lowest-index 0 column c is latched with r, and the FSM goes to PRESS_DB with row_out still driving row r. Otherwise r advances.
- PRESS_DB state:
  - Counts cycles while col_s[c]==0.
  - If col_s[c]==1 before the count reaches DEBOUNCE_CNT, the counter clears and the FSM returns to SCAN at row r+1.
  - When the count reaches DEBOUNCE_CNT, the key is committed and the FSM goes to HELD.
- Commit rules:
  - If key_valid=0, or key_ack=1 in the commit cycle: key_code={r,c} and key_valid=1 on the next edge.
  - Otherwise key_code is unchanged and overrun is set to 1.
- HELD state:
  - Waits for col_s[c]==1 for DEBOUNCE_CNT consecutive cycles; any 0 restarts the count.
  - When the count completes, the FSM goes to SCAN at row r+1 with a fresh SCAN_DIV period.
  - Other keys are ignored in HELD; only column c is watched.
- Handshake:
  - key_valid stays high until a cycle where key_ack=1. It clears on the following edge, as does overrun, unless a commit happens in the same cycle.
  - key_ack while key_valid=0 has no effect.
- Simultaneous ack and commit: the new code is loaded, key_valid stays 1, and overrun is cleared, not set.
- Latency: from a stable press to key_valid=1 takes at most 4*SCAN_DIV + 2 + DEBOUNCE_CNT + 1 cycles.
- Counter widths: the row-period counter is sized by $clog2(SCAN_DIV), the debounce counter by $clog2(DEBOUNCE_CNT+1). Neither wraps; each saturates or clears as specified above.
- Reset mid-debounce or mid-hold aborts everything to the reset values. A key already held when reset is released is detected as a new press.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- When defined:
  - In HELD, a repeat counter runs while col_s[c]==0.
  - When it reaches REPEAT_DELAY, the same code is committed again under the normal commit rules, including overrun, and the counter restarts.
  - Any release glitch clears the repeat counter.
- When not defined: no repeat logic or counter is built, REPEAT_DELAY is unused, and exactly one commit occurs per press.

Test Plan (SCAN_DIV=8, DEBOUNCE_CNT=16, REPEAT_DELAY=64 for simulation):
- Reset: assert rst with col_in=4'hF -> row_out=4'b1110, key_valid=0, overrun=0. After release, row_out cycles 1110,1101,1011,0111 every 8 cycles.
- Clean press at row 2, col 1 (col_in[1]=0 while row_out[2]=0), held -> key_code=4'h9 and key_valid=1 within 51 cycles. Valid holds until key_ack; it is 0 one cycle after ack.
- Bounce: col_in[0] low for 10 cycles, then high -> key_valid never asserts and scanning resumes at the next row.
- Long hold (macro off): hold key 5 for 500 cycles, ack, release, press again -> exactly two commits, both key_code=4'h5.
- Overrun: commit 4'h5 with no ack, then release and press 4'hA -> key_code stays 5, overrun=1. A key_ack clears both key_valid and overrun.
- Macro on, hold key 3 for 200 cycles, acking each event -> the first commit is followed by repeat commits every 64 cycles, all key_code=4'h3.
